load_store_unit: RTL and testbench

//  Core-side initiator for the word-wide data_mem (ren/wen/addr/data_i/data_o).
//  - Accepts one load/store request at a time from the execute stage.
//  - Converts byte/half/word RV32 accesses into word-wide memory cycles.
//  - Sub-word stores use read-modify-write, since data_mem has no byte enables.
//  - Returns sign/zero-extended load data with a single-cycle response pulse.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 41 ++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states, access sizes
// and the registered request record.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  typedef struct packed {
    logic      store;
    lsu_size_e size;
    logic      uns;
    logic [1:0] off;
  } lsu_req_t;

  // Unknown encodings fall back to a full word; BU/HU are load-only codes.
  function automatic lsu_size_e decode_size(input logic store, input logic [2:0] f3);
    if (f3 == F3_B || (!store && f3 == F3_BU)) return SZ_B;
    if (f3 == F3_H || (!store && f3 == F3_HU)) return SZ_H;
    if (f3 == F3_W) return SZ_W;
    return SZ_W;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: extends loaded sub-words and merges store data
// into the previously read memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rd_word,
  input  lsu_size_e       size,
  input  logic            uns,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] new_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rd_word[{off, 3'b000} +: 8];
  assign lane_h = rd_word[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_data   = rd_word;
    merged_word = new_data;
    case (size)
      SZ_B: begin
        load_data = {{(XLEN-8){lane_b[7] & ~uns}}, lane_b};
        merged_word = rd_word;
        merged_word[{off, 3'b000} +: 8] = new_data[7:0];
      end
      SZ_H: begin
        load_data = {{(XLEN-16){lane_h[15] & ~uns}}, lane_h};
        merged_word = rd_word;
        merged_word[{off[1], 4'b0000} +: 16] = new_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-wide data_mem; sub-word
// stores are read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 20,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  // req: a transfer happens on a rising edge where req_valid && req_ready;
  // fields are captured then and ignored afterwards. rsp_valid is a 1-cycle pulse.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output lsu_state_e        dbg_state
);

  lsu_state_e      state, state_next;
  lsu_req_t        req_q;
  logic [MEM_AW-1:0] addr_q;
  logic [XLEN-1:0] wr_q, rdata_q;
  logic            err_q;

  lsu_size_e       req_size;
  logic            req_uns;
  logic [1:0]      req_off;
  logic            trap;
  logic            accept;
  logic [XLEN-1:0] load_data, merged_word;
  logic            unused_addr_hi;

  assign req_size       = decode_size(req_store, req_funct3);
  assign req_uns        = !req_store && req_funct3[2];
  assign accept         = req_valid && (state == IDLE);
  assign unused_addr_hi = ^req_addr[XLEN-1:MEM_AW];

`ifdef MISALIGN_TRAP_EN
  assign req_off = req_addr[1:0];
  assign trap    = (req_size == SZ_H && req_addr[0]) ||
                   (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
  // Without trapping, misaligned low bits are simply dropped.
  always_comb begin
    req_off = req_addr[1:0];
    if (req_size == SZ_H) req_off = {req_addr[1], 1'b0};
    if (req_size == SZ_W) req_off = 2'b00;
  end
  assign trap = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (trap)                                state_next = RESP;
          else if (req_store && req_size == SZ_W)  state_next = WR;
          else                                     state_next = RD;
        end
      end
      RD:      state_next = RD_WAIT;
      RD_WAIT: state_next = req_q.store ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_q   <= '{store: req_store, size: req_size, uns: req_uns, off: req_off};
        addr_q  <= {req_addr[MEM_AW-1:2], 2'b00};
        wr_q    <= req_wdata;
        rdata_q <= '0;
        err_q   <= trap;
      end
      // Read data arrives during RD_WAIT: either the load result or the RMW merge.
      if (state == RD_WAIT) begin
        if (req_q.store) wr_q    <= merged_word;
        else             rdata_q <= load_data;
      end
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .rd_word     (mem_rdata),
    .size        (req_q.size),
    .uns         (req_q.uns),
    .off         (req_q.off),
    .new_data    (wr_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_ren   = (state == RD);
  assign mem_wen   = (state == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: data_mem model, randomized requests scored
// against an arithmetic reference of the access rules.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_ren, mem_wen;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [19:0] mem_addr;
  lsu_state_e  dbg_state;

  load_store_unit #(.MEM_AW(20), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data_mem model: registered read, write on wen
  logic [31:0] tb_mem [int];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= tb_mem.exists(int'(mem_addr >> 2)) ? tb_mem[int'(mem_addr >> 2)] : 32'h0;
    if (mem_wen) tb_mem[int'(mem_addr >> 2)] = mem_wdata;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
    logic [1:0]  nren;
    logic [1:0]  nwen;
    logic [31:0] acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          n_vec = 0, n_mis = 0;
  int          ren_cnt = 0, wen_cnt = 0;
  logic [31:0] cur_waddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory semantics computed with plain arithmetic.
  function automatic exp_t ref_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] acc);
    exp_t e;
    int unsigned size, off, ba;
    int widx;
    bit uns;
    logic [31:0] word, mask, val;
    e = '0;
    e.acc = acc;
    if (st) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    uns  = !st && f3[2] && size < 4;
    ba   = a % 32'h0010_0000;
    off  = ba % 4;
    widx = int'(ba / 4);
`ifdef MISALIGN_TRAP_EN
    if (off % size != 0) begin
      e.err = 1'b1;
      e.lat = 8'd1;
      return e;
    end
`endif
    off  = off - off % size;
    word = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (!st) begin
      val = (word >> (8 * off)) & mask;
      if (!uns && size < 4 && val[8 * size - 1]) val = val | ~mask;
      e.rdata = val;
      e.lat   = 8'd3;
      e.nren  = 2'd1;
    end else begin
      ref_mem[widx] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      e.nwen = 2'd1;
      e.nren = (size < 4) ? 2'd1 : 2'd0;
      e.lat  = (size < 4) ? 8'd4 : 8'd2;
    end
    return e;
  endfunction

  // driver
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit track);
    bit rdy = 1'b0;
    int n = 0;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!rdy && n < 100) begin
      @(negedge clk) rdy = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    if (!rdy) begin
      n_vec++; n_mis++;
      $display("FAIL accept_timeout: got req_ready=0 for 100 cycles required 1");
    end else begin
      cur_waddr = a & 32'h000F_FFFC;
      if (track) exp_q.push_back(ref_op(st, f3, a, wd, cyc));
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_mis++;
      $display("FAIL drain_timeout: got %0d pending responses required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_ren || mem_wen) begin
        chk("strobe_overlap", {31'b0, mem_ren & mem_wen}, 32'h0);
        chk("mem_addr", {12'b0, mem_addr}, cur_waddr);
        if (mem_ren) ren_cnt++;
        if (mem_wen) wen_cnt++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h required no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("latency", cyc - e.acc + 1, {24'b0, e.lat});
          chk("ren_count", ren_cnt, {30'b0, e.nren});
          chk("wen_count", wen_cnt, {30'b0, e.nwen});
          chk("ready_busy", {31'b0, req_ready}, 32'h0);
          ren_cnt = 0;
          wen_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_wen, saw_rsp;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_mem_ren", {31'b0, mem_ren}, 32'h0);
    chk("rst_mem_wen", {31'b0, mem_wen}, 32'h0);
    chk("rst_mem_addr", {12'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;

    // store then load a word
    issue(1'b1, F3_W, 32'h4, 32'h3, 1'b1);
    issue(1'b0, F3_W, 32'h4, 32'h0, 1'b1);
    drain();
    // byte RMW and byte loads
    issue(1'b1, F3_W, 32'h8, 32'h1122_3344, 1'b1);
    issue(1'b1, F3_B, 32'h9, 32'h0000_00AB, 1'b1);
    issue(1'b0, F3_W, 32'h8, 32'h0, 1'b1);
    issue(1'b0, F3_BU, 32'h9, 32'h0, 1'b1);
    issue(1'b0, F3_B, 32'h9, 32'h0, 1'b1);
    drain();
    // half loads with sign/zero extension
    issue(1'b1, F3_W, 32'hC, 32'h8001_7FFF, 1'b1);
    issue(1'b0, F3_H, 32'hE, 32'h0, 1'b1);
    issue(1'b0, F3_HU, 32'hE, 32'h0, 1'b1);
    issue(1'b0, F3_H, 32'hC, 32'h0, 1'b1);
    // misaligned word, undefined funct3, wrapped address
    issue(1'b0, F3_W, 32'h6, 32'h0, 1'b1);
    issue(1'b0, 3'b011, 32'h4, 32'h0, 1'b1);
    issue(1'b1, F3_H, 32'hFFF0_0012, 32'hBEEF_CAFE, 1'b1);
    issue(1'b0, F3_W, 32'h0000_0010, 32'h0, 1'b1);
    drain();

    // reset right after a sub-word store is accepted
    issue(1'b1, F3_B, 32'h8, 32'h0000_00CD, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
    saw_wen = 1'b0; saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_wen |= mem_wen;
      saw_rsp |= rsp_valid;
    end
    chk("rst_abort_wen", {31'b0, saw_wen}, 32'h0);
    chk("rst_abort_rsp", {31'b0, saw_rsp}, 32'h0);
    ren_cnt = 0; wen_cnt = 0;
    @(posedge clk); #1;
    issue(1'b0, F3_W, 32'h8, 32'h0, 1'b1);
    drain();

    // three back-to-back loads with req_valid held
    for (int i = 0; i < 3; i++) issue(1'b0, F3_W, 32'h4 * (i + 1), 32'h0, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom & 32'hFFF0_003F, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    foreach (ref_mem[k])
      chk("mem_final", tb_mem.exists(k) ? tb_mem[k] : 32'hxxxx_xxxx, ref_mem[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
